encr_payload_read_ctrl: RTL and testbench

//  Read-side controller for the encryption payload FIFO. Drives that FIFO's stop-read input from a fixed frame slot map.

---
 rtl/encr_payload_read_ctrl_pkg.sv | 8 +
 rtl/encr_justif_decider.sv | 22 ++
 rtl/encr_payload_read_ctrl.sv | 81 ++++++++
 tb/tb_encr_payload_read_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encr_payload_read_ctrl_pkg.sv
// encr_payload_read_ctrl_pkg: justification and state encodings shared with the frame mapper and deframer
package encr_payload_read_ctrl_pkg;
  localparam logic [1:0] JC_NONE = 2'b00;
  localparam logic [1:0] JC_POS  = 2'b01;
  localparam logic [1:0] JC_NEG  = 2'b10;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/encr_justif_decider.sv
// encr_justif_decider: fill level vs thresholds -> justification, sampled once per frame
module encr_justif_decider
  import encr_payload_read_ctrl_pkg::*;
#(
  parameter int NB_ADRESS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [NB_ADRESS-1:0] level,
  input  logic [NB_ADRESS-1:0] low,
  input  logic [NB_ADRESS-1:0] high,
  output logic [1:0]           decision,
  output logic [1:0]           justif
);
  // low wins when the thresholds overlap
  assign decision = (level <= low) ? JC_POS : (level >= high) ? JC_NEG : JC_NONE;
  always_ff @(posedge clk)
    if (rst || clear) justif <= JC_NONE;
    else if (sample) justif <= decision;
endmodule

// File: rtl/encr_payload_read_ctrl.sv
// encr_payload_read_ctrl: slot-map driven stop-read for the encryption payload FIFO with one justification pair.
// Define ENCR_PAYLOAD_READ_CTRL_STATS_EN to build the pjo/njo event counters.
module encr_payload_read_ctrl
  import encr_payload_read_ctrl_pkg::*;
#(
  parameter int NB_ADRESS  = 3,
  parameter int N_SLOTS    = 16,
  parameter int NB_SLOT    = 4,
  parameter int N_OVH      = 2,
  parameter int NB_COUNTER = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rf_static_enable,
  input  logic [NB_ADRESS-1:0]  i_fifo_level,
  input  logic [NB_ADRESS-1:0]  i_rf_static_start_level,
  input  logic [NB_ADRESS-1:0]  i_rf_static_low_threshold,
  input  logic [NB_ADRESS-1:0]  i_rf_static_high_threshold,
  input  logic                  i_frame_sync,
  output logic                  o_stop_read,
  output logic                  o_frame_start,
  output logic                  o_ovh_slot,
  output logic [1:0]            o_justif_ctrl,
  output logic                  o_running,
  output logic [NB_COUNTER-1:0] o_rf_static_pjo_counter,
  output logic [NB_COUNTER-1:0] o_rf_static_njo_counter
);
  localparam logic [NB_SLOT-1:0] LAST = NB_SLOT'(N_SLOTS - 1);
  localparam logic [NB_SLOT-1:0] NJO  = NB_SLOT'(N_OVH - 1);
  localparam logic [NB_SLOT-1:0] PJO  = NB_SLOT'(N_OVH);
  logic [0:0]         state;
  logic [NB_SLOT-1:0] slot;
  logic [1:0]         justif;
  logic [1:0]         decision;
  logic               running;
  logic               sample;
  assign running = state == ST_RUN;
  // a sync in the last slot discards the decision instead of latching it
  assign sample  = running && slot == LAST && !i_frame_sync;
  always_ff @(posedge i_clock)
    if (i_reset || !i_rf_static_enable) begin
      state <= ST_IDLE;
      slot  <= '0;
    end else if (!running) begin
      state <= (i_fifo_level >= i_rf_static_start_level) ? ST_RUN : ST_IDLE;
      slot  <= '0;
    end else slot <= (i_frame_sync || slot == LAST) ? '0 : slot + NB_SLOT'(1);
  encr_justif_decider #(.NB_ADRESS(NB_ADRESS)) u_decider (
    .clk      (i_clock),
    .rst      (i_reset),
    .clear    (!i_rf_static_enable || !running || i_frame_sync),
    .sample   (sample),
    .level    (i_fifo_level),
    .low      (i_rf_static_low_threshold),
    .high     (i_rf_static_high_threshold),
    .decision (decision),
    .justif   (justif)
  );
  assign o_stop_read   = !running || slot < NJO || (slot == NJO && justif != JC_NEG) ||
                         (slot == PJO && justif == JC_POS);
  assign o_frame_start = running && slot == '0;
  assign o_ovh_slot    = running && slot < PJO;
  assign o_justif_ctrl = justif;
  assign o_running     = running;
`ifdef ENCR_PAYLOAD_READ_CTRL_STATS_EN
  // counted on the edge that opens the justified frame
  always_ff @(posedge i_clock)
    if (i_reset || !i_rf_static_enable) begin
      o_rf_static_pjo_counter <= '0;
      o_rf_static_njo_counter <= '0;
    end else if (sample) begin
      o_rf_static_pjo_counter <= o_rf_static_pjo_counter + NB_COUNTER'(decision == JC_POS);
      o_rf_static_njo_counter <= o_rf_static_njo_counter + NB_COUNTER'(decision == JC_NEG);
    end
`else
  logic decision_unused;
  assign decision_unused = ^decision;
  assign o_rf_static_pjo_counter = '0;
  assign o_rf_static_njo_counter = '0;
`endif
endmodule

// File: tb/tb_encr_payload_read_ctrl.sv
// tb_encr_payload_read_ctrl: scoreboard bench for the payload read controller, default parameters
module tb_encr_payload_read_ctrl;
  localparam bit STATS =
`ifdef ENCR_PAYLOAD_READ_CTRL_STATS_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct packed {logic stop; logic fs; logic ovh; logic [1:0] j;} exp_t;
  logic clk = 1'b0;
  logic rst, en, sync;
  logic [2:0] level, start, low, high;
  logic stop_read, frame_start, ovh_slot, running;
  logic [1:0] justif;
  logic [15:0] pjo, njo;
  int checks = 0;
  int errors = 0;
  int pjo_m = 0;
  int njo_m = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  encr_payload_read_ctrl dut (
    .i_clock                    (clk),
    .i_reset                    (rst),
    .i_rf_static_enable         (en),
    .i_fifo_level               (level),
    .i_rf_static_start_level    (start),
    .i_rf_static_low_threshold  (low),
    .i_rf_static_high_threshold (high),
    .i_frame_sync               (sync),
    .o_stop_read                (stop_read),
    .o_frame_start              (frame_start),
    .o_ovh_slot                 (ovh_slot),
    .o_justif_ctrl              (justif),
    .o_running                  (running),
    .o_rf_static_pjo_counter    (pjo),
    .o_rf_static_njo_counter    (njo)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_frame(input logic [1:0] j);
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      e.stop = (s == 0) || (s == 1 && j != 2'b10) || (s == 2 && j == 2'b01);
      e.fs   = (s == 0);
      e.ovh  = (s < 2);
      e.j    = j;
      q.push_back(e);
    end
  endtask
  task automatic test_reset;
    rst = 1; en = 1; sync = 0; level = 0; start = 4; low = 1; high = 6;
    tick; tick;
    checks++;
    if ({stop_read, frame_start, ovh_slot, running, justif} !== 6'b100000 || pjo !== 0 || njo !== 0) begin
      errors++;
      $display("FAIL reset outs=%b pjo=%0d njo=%0d expected outs=100000 counters 0",
               {stop_read, frame_start, ovh_slot, running, justif}, pjo, njo);
    end
    rst = 0;
  endtask
  task automatic test_start;
    for (int l = 0; l < 4; l++) begin
      level = 3'(l);
      tick;
      checks++;
      if (running !== 1'b0 || stop_read !== 1'b1) begin
        errors++;
        $display("FAIL start_idle level=%0d running=%b stop=%b expected running=0 stop=1", l, running, stop_read);
      end
    end
    level = 4;
    push_frame(2'b00);
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      if (s > 0) tick;
      else begin
        tick;
        checks++;
        if (running !== 1'b1) begin
          errors++;
          $display("FAIL start_run running=%b expected 1", running);
        end
      end
      e = q.pop_front();
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL start_frame slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
  endtask
  task automatic test_neutral;
    int stops = 0;
    level = 3;
    push_frame(2'b00);
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      tick;
      e = q.pop_front();
      stops += int'(stop_read);
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL neutral slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (stops !== 2 || pjo !== 0 || njo !== 0) begin
      errors++;
      $display("FAIL neutral_count stops=%0d pjo=%0d njo=%0d expected 2 0 0", stops, pjo, njo);
    end
  endtask
  task automatic test_pos;
    int stops = 0;
    level = 1;
    push_frame(2'b01);
    pjo_m++;
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      tick;
      e = q.pop_front();
      stops += int'(stop_read);
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL pos slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (stops !== 3 || pjo !== 16'(STATS ? pjo_m : 0) || njo !== 0) begin
      errors++;
      $display("FAIL pos_count stops=%0d pjo=%0d njo=%0d expected 3 %0d 0", stops, pjo, njo, STATS ? pjo_m : 0);
    end
  endtask
  task automatic test_neg;
    int stops = 0;
    level = 7;
    push_frame(2'b10);
    njo_m++;
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      tick;
      e = q.pop_front();
      stops += int'(stop_read);
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL neg slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (stops !== 1 || pjo !== 16'(STATS ? pjo_m : 0) || njo !== 16'(STATS ? njo_m : 0)) begin
      errors++;
      $display("FAIL neg_count stops=%0d pjo=%0d njo=%0d expected 1 %0d %0d", stops, pjo, njo,
               STATS ? pjo_m : 0, STATS ? njo_m : 0);
    end
  endtask
  task automatic test_back_to_back;
    push_frame(2'b10);
    push_frame(2'b01);
    njo_m++;
    pjo_m++;
    level = 6;
    for (int s = 0; s < 32; s++) begin
      exp_t e;
      tick;
      if (s == 0) level = 1;
      e = q.pop_front();
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL b2b cycle=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (pjo !== 16'(STATS ? pjo_m : 0) || njo !== 16'(STATS ? njo_m : 0)) begin
      errors++;
      $display("FAIL b2b_count pjo=%0d njo=%0d expected %0d %0d", pjo, njo, STATS ? pjo_m : 0, STATS ? njo_m : 0);
    end
  endtask
  task automatic test_frame_sync;
    level = 1;
    sync = 1;
    push_frame(2'b00);
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      tick;
      sync = 0;
      if (s == 1) level = 3;
      e = q.pop_front();
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL sync slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (pjo !== 16'(STATS ? pjo_m : 0)) begin
      errors++;
      $display("FAIL sync_count pjo=%0d expected %0d", pjo, STATS ? pjo_m : 0);
    end
    level = 1;
    pjo_m++;
    for (int s = 0; s < 5; s++) begin
      tick;
      level = 3;
    end
    checks++;
    if (justif !== 2'b01 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL sync_pre justif=%b fs=%b expected 01 0", justif, frame_start);
    end
    sync = 1;
    tick;
    sync = 0;
    checks++;
    if (frame_start !== 1'b1 || justif !== 2'b00 || stop_read !== 1'b1) begin
      errors++;
      $display("FAIL sync_mid fs=%b justif=%b stop=%b expected 1 00 1", frame_start, justif, stop_read);
    end
    for (int s = 0; s < 15; s++) tick;
    checks++;
    if (pjo !== 16'(STATS ? pjo_m : 0) || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL sync_end pjo=%0d fs=%b expected %0d 0", pjo, frame_start, STATS ? pjo_m : 0);
    end
  endtask
  task automatic test_disable;
    for (int s = 0; s < 8; s++) tick;
    en = 0;
    tick;
    pjo_m = 0;
    njo_m = 0;
    checks++;
    if ({stop_read, frame_start, ovh_slot, running, justif} !== 6'b100000 || pjo !== 0 || njo !== 0) begin
      errors++;
      $display("FAIL disable outs=%b pjo=%0d njo=%0d expected outs=100000 counters 0",
               {stop_read, frame_start, ovh_slot, running, justif}, pjo, njo);
    end
    en = 1;
    sync = 1;
    tick;
    sync = 0;
    checks++;
    if (running !== 1'b0 || frame_start !== 1'b0 || stop_read !== 1'b1) begin
      errors++;
      $display("FAIL idle_sync running=%b fs=%b stop=%b expected 0 0 1", running, frame_start, stop_read);
    end
  endtask
  task automatic test_overlap;
    level = 4;
    tick;
    checks++;
    if (running !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL restart running=%b fs=%b expected 1 1", running, frame_start);
    end
    for (int s = 0; s < 15; s++) tick;
    low = 5;
    high = 3;
    push_frame(2'b01);
    pjo_m++;
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      tick;
      e = q.pop_front();
      checks++;
      if ({stop_read, frame_start, ovh_slot, justif} !== e) begin
        errors++;
        $display("FAIL overlap slot=%0d got=%b expected=%b", s, {stop_read, frame_start, ovh_slot, justif}, e);
      end
    end
    checks++;
    if (pjo !== 16'(STATS ? pjo_m : 0) || njo !== 0) begin
      errors++;
      $display("FAIL overlap_count pjo=%0d njo=%0d expected %0d 0", pjo, njo, STATS ? pjo_m : 0);
    end
  endtask
  initial begin
    test_reset;
    test_start;
    test_neutral;
    test_pos;
    test_neg;
    test_back_to_back;
    test_frame_sync;
    test_disable;
    test_overlap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
